fetch_redirect_ctrl: RTL

//   Sequences the fetch-to-IF/ID path on control-flow redirects. Sits between the IFU fetch response and the
//   IF/ID pipe stage: passes responses through in normal flow, and on a redirect from EXU flushes IF/ID and

---
 rtl/fetch_redirect_ctrl_if.sv | 61 ++++++
 rtl/fetch_redirect_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl_if.sv
// Purpose : bundles the fetch-response, IF/ID and redirect signals that
//           surround fetch_redirect_ctrl into one interface.
// Ports   : redirect_* from EXU, ifu_* to/from IFU, f_* to/from IF/ID,
//           flush_o to IF/ID+IDU, pc_redirect_* to IFU.
// Modports: slave  = the redirect controller itself (drives the *_o nets)
//           master = the surrounding pipeline (drives the *_i nets)
interface fetch_redirect_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);

  // EXU redirect request
  logic              redirect_valid_i;
  logic [PC_W-1:0]   redirect_pc_i;

  // IFU request metering
  logic              ifu_req_fire_i;
  logic              ifu_req_allow_o;

  // IFU fetch response
  logic              ifu_rsp_valid_i;
  logic [INST_W-1:0] ifu_rsp_inst_i;
  logic [PC_W-1:0]   ifu_rsp_pc_i;
  logic              ifu_rsp_ready_o;

  // IF/ID stage
  logic              f_valid_o;
  logic [INST_W-1:0] f_inst_o;
  logic [PC_W-1:0]   f_pc_o;
  logic              f_ready_i;
  logic              flush_o;

  // new pc to IFU
  logic              pc_redirect_valid_o;
  logic [PC_W-1:0]   pc_redirect_o;

  modport slave (
    input  redirect_valid_i, redirect_pc_i,
    input  ifu_req_fire_i,
    output ifu_req_allow_o,
    input  ifu_rsp_valid_i, ifu_rsp_inst_i, ifu_rsp_pc_i,
    output ifu_rsp_ready_o,
    output f_valid_o, f_inst_o, f_pc_o,
    input  f_ready_i,
    output flush_o,
    output pc_redirect_valid_o, pc_redirect_o
  );

  modport master (
    output redirect_valid_i, redirect_pc_i,
    output ifu_req_fire_i,
    input  ifu_req_allow_o,
    output ifu_rsp_valid_i, ifu_rsp_inst_i, ifu_rsp_pc_i,
    input  ifu_rsp_ready_o,
    input  f_valid_o, f_inst_o, f_pc_o,
    output f_ready_i,
    input  flush_o,
    input  pc_redirect_valid_o, pc_redirect_o
  );

endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Purpose : sequences fetch responses into IF/ID; on an EXU redirect it
//           flushes IF/ID, forwards the new pc to the IFU one cycle later
//           and silently consumes every wrong-path response still in flight.
//           Also meters outstanding IFU requests (at most MAX_OUT).
// Latency : response -> IF/ID is combinational (0 cycles) in RUN;
//           redirect -> pc_redirect_valid_o/pc_redirect_o is 1 cycle.
// Backpressure: in RUN ifu_rsp_ready_o follows f_ready_i; during a redirect
//           cycle and in DRAIN responses are always accepted and dropped.
// Ports   : clk_i, rst_i (async, active-high) plus bus (fetch_redirect_ctrl_if.slave).
// Option  : define YSYX_23060251_REDIRECT_STATS_EN to add saturating
//           redirect_cnt_o / dropped_cnt_o statistics ports.
module fetch_redirect_ctrl #(
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fetch_redirect_ctrl_if.slave  bus
`ifdef YSYX_23060251_REDIRECT_STATS_EN
  ,
  output logic [31:0]           redirect_cnt_o,
  output logic [31:0]           dropped_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  out_cnt_nxt;
  logic              pc_redirect_valid_q;
  logic [PC_W-1:0]   pc_redirect_q;

  logic              redirect;
  logic              in_drain;
  logic              rsp_ready;
  logic              rsp_fire;
  logic              req_fire;
  logic [INST_W-1:0] rsp_inst;
  logic [PC_W-1:0]   rsp_pc;

  assign redirect = bus.redirect_valid_i;
  assign in_drain = (state == DRAIN);
  assign req_fire = bus.ifu_req_fire_i;
  assign rsp_inst = bus.ifu_rsp_inst_i;
  assign rsp_pc   = bus.ifu_rsp_pc_i;

  // Anything arriving in a redirect cycle or while draining is wrong-path,
  // so it is accepted unconditionally and never shown to IF/ID.
  assign rsp_ready = redirect | in_drain | bus.f_ready_i;
  assign rsp_fire  = bus.ifu_rsp_valid_i & rsp_ready;

  assign bus.ifu_rsp_ready_o = rsp_ready;
  assign bus.f_valid_o       = bus.ifu_rsp_valid_i & ~redirect & ~in_drain;
  assign bus.f_inst_o        = rsp_inst;
  assign bus.f_pc_o          = rsp_pc;
  assign bus.flush_o         = redirect;
  assign bus.ifu_req_allow_o = ~in_drain & (out_cnt < MAX_CNT) & ~redirect;

  assign bus.pc_redirect_valid_o = pc_redirect_valid_q;
  assign bus.pc_redirect_o       = pc_redirect_q;

  // Outstanding-request count for the next cycle; a request and a response
  // in the same cycle cancel out.
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (req_fire && !rsp_fire) begin
      out_cnt_nxt = out_cnt + ONE;
    end else if (!req_fire && rsp_fire) begin
      out_cnt_nxt = out_cnt - ONE;
    end
  end

  // Control FSM with its registered outputs (pc redirect pulse, counters).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= RUN;
      out_cnt             <= '0;
      drop_cnt            <= '0;
      pc_redirect_valid_q <= 1'b0;
      pc_redirect_q       <= '0;
    end else begin
      out_cnt             <= out_cnt_nxt;
      pc_redirect_valid_q <= 1'b0;

      if (redirect) begin
        // Everything still outstanding after this cycle belongs to the old
        // path. A redirect while already draining simply restarts the drain
        // with the newest target.
        pc_redirect_valid_q <= 1'b1;
        pc_redirect_q       <= bus.redirect_pc_i;
        drop_cnt            <= out_cnt_nxt;
        state               <= (out_cnt_nxt != '0) ? DRAIN : RUN;
      end else begin
        case (state)
          RUN: begin
            state <= RUN;
          end
          DRAIN: begin
            if (drop_cnt == '0) begin
              state <= RUN;
            end else if (rsp_fire) begin
              drop_cnt <= drop_cnt - ONE;
              if (drop_cnt == ONE) begin
                state <= RUN;
              end
            end
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

`ifdef YSYX_23060251_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] dropped_cnt_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_cnt_q <= '0;
      dropped_cnt_q  <= '0;
    end else begin
      if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
      if (rsp_fire && (redirect || in_drain) && (dropped_cnt_q != 32'hFFFF_FFFF)) begin
        dropped_cnt_q <= dropped_cnt_q + 32'd1;
      end
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign dropped_cnt_o  = dropped_cnt_q;
`endif

  // Protocol checks on the IFU side. The redirect arrives late in the cycle,
  // so a request the IFU launched in that same cycle is legal: it is counted
  // and later drained like any other wrong-path fetch.
  a_req_allowed : assert property (@(posedge clk_i) disable iff (rst_i)
    req_fire |-> (bus.ifu_req_allow_o | redirect));

  a_req_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_fire & ~rsp_fire) |-> (out_cnt != MAX_CNT));

  a_rsp_outstanding : assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_fire |-> (out_cnt != '0));

endmodule
